// File: rtl/platform_collision_if.sv
// Bundle between the platform position generator / player motion and the
// landing detector: frame edge, doodle and platform coordinates in; landing event out.
interface platform_collision_if #(
  parameter int NUM_PLAT = 8
);
  logic [1:0] frame_clk_edge;
  logic [9:0] Ball_X;
  logic [9:0] Ball_Y;
  logic [9:0] Ball_size;
  logic       Ball_falling;
  logic [7:0] platform_size;
  logic [9:0] Platform_X_in [0:NUM_PLAT-1];
  logic [9:0] Platform_Y_in [0:NUM_PLAT-1];
  logic       land;
  logic [2:0] land_idx;
  logic [9:0] land_Y;
  logic       busy;
  logic [15:0] score;

  modport master (
    output frame_clk_edge, Ball_X, Ball_Y, Ball_size, Ball_falling,
    output platform_size, Platform_X_in, Platform_Y_in,
    input  land, land_idx, land_Y, busy, score
  );

  modport slave (
    input  frame_clk_edge, Ball_X, Ball_Y, Ball_size, Ball_falling,
    input  platform_size, Platform_X_in, Platform_Y_in,
    output land, land_idx, land_Y, busy, score
  );
endinterface

// File: rtl/platform_collision.sv
// Per-frame landing detector: snapshots 8 platforms + doodle on a frame
// edge, scans one platform per clock, emits at most one landing per frame.
// Ports: Clk, Reset (sync, active-high), bus (platform_collision_if.slave):
//   in  frame_clk_edge, Ball_X/Y/size, Ball_falling, platform_size,
//       Platform_X_in[], Platform_Y_in[]
//   out land, land_idx, land_Y, busy, score
// Option: define PLATFORM_COLLISION_SCORE_EN to build the landing counter;
// otherwise score is tied to zero.
module platform_collision #(
  parameter int Y_TOL    = 4,
  parameter int NUM_PLAT = 8
) (
  input logic Clk,
  input logic Reset,
  platform_collision_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state;

  logic [9:0] s_px [NUM_PLAT];
  logic [9:0] s_py [NUM_PLAT];
  logic [9:0] s_bx;
  logic [9:0] s_by;
  logic [9:0] s_bs;
  logic       s_fall;
  logic [7:0] s_ps;

  logic [2:0] idx;
  logic       hit_flag;
  logic [2:0] hit_idx;
  logic [9:0] hit_py;

  logic [10:0] feet;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] bx;
  logic [10:0] bs;
  logic [10:0] ps;
  logic        hit_now;
  logic        take;
  logic        last;
  logic        found;
  logic [2:0]  sel_idx;
  logic [9:0]  sel_py;
  logic [9:0]  snap_y;
  logic        fire;

  // 11-bit zero-extended compare so no sum can wrap
  always_comb begin
    px      = {1'b0, s_px[idx]};
    py      = {1'b0, s_py[idx]};
    bx      = {1'b0, s_bx};
    bs      = {1'b0, s_bs};
    ps      = {3'b000, s_ps};
    feet    = {1'b0, s_by} + bs;
    hit_now = s_fall
            && (feet >= py)
            && (feet <= py + 11'(Y_TOL))
            && (bx + bs > px)
            && (bx < px + ps);
    take    = hit_now && !hit_flag;
    last    = (idx == 3'(NUM_PLAT - 1));
    found   = hit_flag || take;
    sel_idx = hit_flag ? hit_idx : idx;
    sel_py  = hit_flag ? hit_py : py[9:0];
    snap_y  = (sel_py < s_bs) ? 10'd0 : sel_py - s_bs;
    fire    = (state == SCAN) && last && found;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      idx          <= '0;
      hit_flag     <= 1'b0;
      hit_idx      <= '0;
      hit_py       <= '0;
      bus.land     <= 1'b0;
      bus.land_idx <= '0;
      bus.land_Y   <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.land <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.frame_clk_edge == 2'b01) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
              s_px[i] <= bus.Platform_X_in[i];
              s_py[i] <= bus.Platform_Y_in[i];
            end
            s_bx     <= bus.Ball_X;
            s_by     <= bus.Ball_Y;
            s_bs     <= bus.Ball_size;
            s_fall   <= bus.Ball_falling;
            s_ps     <= bus.platform_size;
            hit_flag <= 1'b0;
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (take) begin
            hit_flag <= 1'b1;
            hit_idx  <= idx;
            hit_py   <= py[9:0];
          end
          idx <= idx + 3'd1;
          if (last) begin
            state    <= DONE;
            bus.land <= found;
            if (found) begin
              bus.land_idx <= sel_idx;
              bus.land_Y   <= snap_y;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLATFORM_COLLISION_SCORE_EN
  logic [15:0] score_q;

  always_ff @(posedge Clk) begin
    if (Reset)
      score_q <= '0;
    else if (fire && score_q != 16'hFFFF)
      score_q <= score_q + 16'd1;
  end

  assign bus.score = score_q;
`else
  logic unused_fire;
  assign unused_fire = fire;
  assign bus.score   = 16'h0000;
`endif

endmodule

// File: tb/tb_platform_collision.sv
// Directed bench for platform_collision: queued landing expectations
// checked at the fixed DONE cycle with immediate assertions.
module tb_platform_collision;

  typedef struct packed {
    logic       fire;
    logic [2:0] idx;
    logic [9:0] y;
  } exp_t;

`ifdef PLATFORM_COLLISION_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  platform_collision_if #(.NUM_PLAT(8)) bus ();

  platform_collision #(
    .Y_TOL(4),
    .NUM_PLAT(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_score = 16'h0;
  logic [2:0] held_idx = 3'd0;
  logic [9:0] held_y = 10'd0;
  exp_t q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_plats();
    for (int i = 0; i < 8; i++) begin
      bus.Platform_X_in[i] = 10'd0;
      bus.Platform_Y_in[i] = 10'd0;
    end
  endtask

  task automatic set_ball(input int x, input int y, input int s,
                          input bit f);
    bus.Ball_X       = 10'(x);
    bus.Ball_Y       = 10'(y);
    bus.Ball_size    = 10'(s);
    bus.Ball_falling = f;
  endtask

  task automatic chk_score(input string tag);
    chk(tag, bus.score, SCORE_EN ? exp_score : 16'h0);
  endtask

  // mode 0: plain frame; 1: move platform 3 and re-pulse frame mid-scan;
  // 2: reset at edge k+3
  task automatic run_frame(input string tag, input logic fire,
                           input logic [2:0] ei, input logic [9:0] ey,
                           input int mode);
    exp_t e;
    logic saw;
    if (mode != 2) q.push_back('{fire: fire, idx: ei, y: ey});
    bus.frame_clk_edge = 2'b01;
    tick();
    bus.frame_clk_edge = 2'b00;
    chk({tag, "_busy_k"}, bus.busy, 1);
    chk({tag, "_land_k"}, bus.land, 0);
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (mode == 2 && j == 3) begin
        chk({tag, "_rst_land"}, bus.land, 0);
        chk({tag, "_rst_idx"}, bus.land_idx, 0);
        chk({tag, "_rst_y"}, bus.land_Y, 0);
        chk({tag, "_rst_busy"}, bus.busy, 0);
        exp_score = 16'h0;
        held_idx  = 3'd0;
        held_y    = 10'd0;
        chk_score({tag, "_rst_score"});
        Reset = 1'b0;
        saw = 1'b0;
        repeat (12) begin
          tick();
          saw |= bus.land;
        end
        chk({tag, "_no_land"}, saw, 0);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        return;
      end
      if (bus.land !== 1'b0 || bus.busy !== 1'b1)
        chk({tag, "_scan"}, {bus.land, bus.busy}, 2'b01);
      if (mode == 1 && j == 1) bus.Platform_Y_in[3] = 10'd0;
      if (mode == 1 && j == 3) bus.frame_clk_edge = 2'b01;
      if (mode == 1 && j == 4) bus.frame_clk_edge = 2'b00;
      if (mode == 2 && j == 2) Reset = 1'b1;
    end
    tick();
    e = q.pop_front();
    if (e.fire) begin
      held_idx = e.idx;
      held_y   = e.y;
      if (exp_score != 16'hFFFF) exp_score = exp_score + 16'd1;
    end
    chk({tag, "_land"}, bus.land, e.fire);
    chk({tag, "_idx"}, bus.land_idx, held_idx);
    chk({tag, "_y"}, bus.land_Y, held_y);
    chk({tag, "_busy_k8"}, bus.busy, 1);
    chk_score({tag, "_score"});
    tick();
    chk({tag, "_land_k9"}, bus.land, 0);
    chk({tag, "_busy_k9"}, bus.busy, 0);
    if (mode == 1) begin
      saw = 1'b0;
      repeat (6) begin
        tick();
        saw |= bus.land | bus.busy;
      end
      chk({tag, "_one_pulse"}, saw, 0);
    end
  endtask

  initial begin
    bus.frame_clk_edge = 2'b00;
    bus.platform_size  = 8'd60;
    set_ball(150, 150, 10, 1'b1);
    clear_plats();

    tick();
    tick();
    chk("reset_land", bus.land, 0);
    chk("reset_idx", bus.land_idx, 0);
    chk("reset_y", bus.land_Y, 0);
    chk("reset_busy", bus.busy, 0);
    chk_score("reset_score");
    Reset = 1'b0;
    tick();

    bus.frame_clk_edge = 2'b11;
    tick();
    bus.frame_clk_edge = 2'b00;
    chk("code11_idle", bus.busy, 0);

    bus.Platform_X_in[3] = 10'd140;
    bus.Platform_Y_in[3] = 10'd160;
    run_frame("single", 1'b1, 3'd3, 10'd150, 0);

    bus.Platform_Y_in[3] = 10'd0;
    bus.Platform_X_in[2] = 10'd140;
    bus.Platform_Y_in[2] = 10'd160;
    bus.Platform_X_in[5] = 10'd140;
    bus.Platform_Y_in[5] = 10'd160;
    run_frame("prio", 1'b1, 3'd2, 10'd150, 0);

    clear_plats();
    bus.Platform_X_in[1] = 10'd140;
    bus.Platform_Y_in[1] = 10'd160;
    set_ball(150, 155, 10, 1'b1);
    run_frame("ytol_out", 1'b0, 3'd0, 10'd0, 0);
    set_ball(150, 154, 10, 1'b1);
    run_frame("ytol_in", 1'b1, 3'd1, 10'd150, 0);
    set_ball(200, 150, 10, 1'b1);
    run_frame("x_right", 1'b0, 3'd0, 10'd0, 0);
    set_ball(130, 150, 10, 1'b1);
    run_frame("x_left", 1'b0, 3'd0, 10'd0, 0);

    clear_plats();
    bus.Platform_X_in[3] = 10'd140;
    bus.Platform_Y_in[3] = 10'd160;
    set_ball(150, 150, 10, 1'b0);
    run_frame("rising", 1'b0, 3'd0, 10'd0, 0);

    clear_plats();
    bus.Platform_X_in[6] = 10'd0;
    bus.Platform_Y_in[6] = 10'd8;
    set_ball(5, 0, 10, 1'b1);
    run_frame("clamp", 1'b1, 3'd6, 10'd0, 0);

    clear_plats();
    bus.Platform_X_in[3] = 10'd140;
    bus.Platform_Y_in[3] = 10'd160;
    set_ball(150, 150, 10, 1'b1);
    run_frame("snap", 1'b1, 3'd3, 10'd150, 1);

    bus.Platform_Y_in[3] = 10'd160;
    run_frame("midrst", 1'b0, 3'd0, 10'd0, 2);
    run_frame("after_rst", 1'b1, 3'd3, 10'd150, 0);

    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
